// File: rtl/safe_pkg.sv
// rtl/safe_pkg.sv - shared token, keypad FSM types and keypad key map
package safe_pkg;

    // Tokens understood by the safe controller's data_in input.
    typedef enum logic [3:0] {
        KEY_0       = 4'd0,
        KEY_1       = 4'd1,
        KEY_2       = 4'd2,
        KEY_3       = 4'd3,
        KEY_4       = 4'd4,
        KEY_5       = 4'd5,
        KEY_6       = 4'd6,
        KEY_7       = 4'd7,
        KEY_8       = 4'd8,
        KEY_9       = 4'd9,
        KEY_CLEAR   = 4'd10,
        KEY_OK      = 4'd11,
        DOOR_SEALED = 4'd12
    } data_in;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        RELEASE
    } kp_state_t;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 3;

    // [row][col]; col 0 is col_i[0].
    localparam data_in KP_MAP [KP_ROWS][KP_COLS] = '{
        '{KEY_1,     KEY_2, KEY_3 },
        '{KEY_4,     KEY_5, KEY_6 },
        '{KEY_7,     KEY_8, KEY_9 },
        '{KEY_CLEAR, KEY_0, KEY_OK}
    };

    // Active-low column pattern seen when only column idx is pressed.
    function automatic logic [2:0] col_pattern(input logic [1:0] idx);
        return ~(3'b001 << idx);
    endfunction

endpackage

// File: rtl/safe_debounce.sv
// rtl/safe_debounce.sv - 2-flop synchroniser followed by a stable-count filter
// Ports: clk_i, rst_ni (sync, active-low), d_i (asynchronous input),
//        q_o (filtered level; follows d_i after DEBOUNCE_CYC stable cycles, resets to 0)
module safe_debounce #(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic          meta_q, sync_q;
    logic          q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the output
    // and stops at LAST, so it can never wrap.
    always_comb begin
        q_d   = q_q;
        cnt_d = '0;
        if (sync_q != q_q) begin
            if (cnt_q == LAST) begin
                q_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            q_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/safe_keypad_encoder.sv
// rtl/safe_keypad_encoder.sv - 4x3 keypad scanner emitting one data_in token per press
// Ports: clk_i, rst_ni (sync, active-low); row_o one-hot active-low row drive;
//        col_i active-low asynchronous columns; door_closed_i door sensor;
//        key_o/key_valid_o/key_ready_i token handshake; overrun_o dropped-token pulse.
// Option: define SAFE_KEYPAD_DOOR_EN to debounce door_closed_i and emit DOOR_SEALED
//         on each closing edge; otherwise door_closed_i is ignored.
import safe_pkg::*;

module safe_keypad_encoder #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [3:0] row_o,
    input  logic [2:0] col_i,
    input  logic       door_closed_i,
    output data_in     key_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic       overrun_o
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);

    kp_state_t     state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    colidx_q, colidx_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]    col_meta_q, col_sync_q;
    data_in        key_q, key_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          hit;
    logic [1:0]    hit_col;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef SAFE_KEYPAD_DOOR_EN
    logic door_db, door_db_q, door_rise;
    logic door_pend_q, door_pend_d;

    safe_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_door_db (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (door_closed_i),
        .q_o   (door_db)
    );

    assign door_rise = door_db && !door_db_q;
`else
    logic unused_door;
    assign unused_door = door_closed_i;
`endif

    // Single-column press decode; zero or multiple low columns are not a hit.
    always_comb begin
        hit     = 1'b0;
        hit_col = 2'd0;
        case (col_sync_q)
            3'b110:  begin hit = 1'b1; hit_col = 2'd0; end
            3'b101:  begin hit = 1'b1; hit_col = 2'd1; end
            3'b011:  begin hit = 1'b1; hit_col = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        colidx_d  = colidx_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && key_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (hit) begin
                        state_d  = DEBOUNCE;
                        colidx_d = hit_col;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DEBOUNCE: begin
                if (col_sync_q != col_pattern(colidx_q)) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            EMIT: begin
                state_d = RELEASE;
                cnt_d   = '0;
                // A handshake this cycle frees the slot in time for the new token.
                if (!valid_q || key_ready_i) begin
                    key_d   = KP_MAP[row_q][colidx_q];
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            RELEASE: begin
                if (col_sync_q != 3'b111) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase

`ifdef SAFE_KEYPAD_DOOR_EN
        // Keypad tokens load only in EMIT, so excluding EMIT gives the keypad priority.
        door_pend_d = door_pend_q || door_rise;
        if (door_pend_q && (state_q != EMIT) && (!valid_q || key_ready_i)) begin
            key_d       = DOOR_SEALED;
            valid_d     = 1'b1;
            door_pend_d = door_rise;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= SCAN;
            row_q      <= 2'd0;
            colidx_q   <= 2'd0;
            cnt_q      <= '0;
            col_meta_q <= 3'b111;
            col_sync_q <= 3'b111;
            key_q      <= KEY_0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            colidx_q   <= colidx_d;
            cnt_q      <= cnt_d;
            col_meta_q <= col_i;
            col_sync_q <= col_meta_q;
            key_q      <= key_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef SAFE_KEYPAD_DOOR_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            door_db_q   <= 1'b0;
            door_pend_q <= 1'b0;
        end else begin
            door_db_q   <= door_db;
            door_pend_q <= door_pend_d;
        end
    end
`endif

    assign row_o       = ~(4'b0001 << row_q);
    assign key_o       = key_q;
    assign key_valid_o = valid_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_safe_keypad_encoder.sv
// tb/tb_safe_keypad_encoder.sv - scoreboard bench for safe_keypad_encoder
import safe_pkg::*;

module tb_safe_keypad_encoder;

    localparam int SD  = 4;
    localparam int DB  = 8;
    localparam int LAT = 4 * SD + DB + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [2:0] col;
    logic       door = 1'b0;
    data_in     key;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       overrun;

    logic       pressed = 1'b0;
    int         p_row = 0;
    int         p_col = 0;
    logic       force_en = 1'b0;
    logic [2:0] force_val = 3'b111;

    int         checks = 0;
    int         failures = 0;
    data_in     sb_q[$];
    int         tok_cnt = 0;
    int         ov_cnt = 0;

    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its column low while its row is driven.
    always_comb begin
        col = 3'b111;
        if (force_en) begin
            col = force_val;
        end else if (pressed && row[p_row] == 1'b0) begin
            col = ~(3'b001 << p_col);
        end
    end

    safe_keypad_encoder #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CYC(DB)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .row_o        (row),
        .col_i        (col),
        .door_closed_i(door),
        .key_o        (key),
        .key_valid_o  (key_valid),
        .key_ready_i  (key_ready),
        .overrun_o    (overrun)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int r, input int c);
        p_row   = r;
        p_col   = c;
        pressed = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!key_valid && k < LAT) begin
            step(1);
            k++;
        end
        check(tag, int'(key_valid), 1);
    endtask

    // Transfers complete at the next posedge; compare against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) ov_cnt++;
            if (key_valid && key_ready) begin
                tok_cnt++;
                check("sb_nonempty", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) check("token", int'(key), int'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0, ov0, k, bad;
        logic [3:0] seen;

        step(3);
        check("rst_row", int'(row), 4'b1110);
        check("rst_valid", int'(key_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_key", int'(key), int'(KEY_0));
        rst_n = 1'b1;

        // Key 5, ready high: one token within the latency bound.
        key_ready = 1'b1;
        t0 = tok_cnt;
        sb_q.push_back(KEY_5);
        press(1, 1);
        wait_valid("t1_latency");
        step(1);
        check("t1_drop", int'(key_valid), 0);
        step(40);
        pressed = 1'b0;
        step(20);
        check("t1_one_token", tok_cnt - t0, 1);

        // Key OK with ready low: held stable until accepted.
        key_ready = 1'b0;
        sb_q.push_back(KEY_OK);
        press(3, 2);
        wait_valid("t2_latency");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (!key_valid || key != KEY_OK) bad++;
        end
        check("t2_stable", bad, 0);
        pressed = 1'b0;
        key_ready = 1'b1;
        step(1);
        check("t2_drop", int'(key_valid), 0);
        key_ready = 1'b0;
        step(20);

        // Overrun: KEY_1 pending, press 9.
        sb_q.push_back(KEY_1);
        press(0, 0);
        wait_valid("t3_first");
        pressed = 1'b0;
        step(20);
        ov0 = ov_cnt;
        press(2, 2);
        k = 0;
        while (ov_cnt == ov0 && k < LAT + 2) begin
            step(1);
            k++;
        end
        check("t3_ov_seen", int'(ov_cnt != ov0), 1);
        pressed = 1'b0;
        step(20);
        check("t3_ov_once", ov_cnt - ov0, 1);
        check("t3_kept_key", int'(key), int'(KEY_1));
        check("t3_kept_valid", int'(key_valid), 1);
        key_ready = 1'b1;
        step(12);
        check("t3_sb_empty", sb_q.size(), 0);

        // Chattering column: no token, scanning resumes.
        t0 = tok_cnt;
        force_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            force_val = (i % 2 == 0) ? 3'b101 : 3'b111;
            step(3);
        end
        force_en = 1'b0;
        step(4);
        seen = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            step(1);
            seen = seen | ~row;
        end
        check("t4_no_token", tok_cnt - t0, 0);
        check("t4_scanning", int'(seen), 4'hf);

        // Reset during DEBOUNCE.
        key_ready = 1'b0;
        press(2, 1);
        k = 0;
        while (row != 4'b1011 && k < 20) begin
            step(1);
            k++;
        end
        step(6);
        check("t5_in_row", int'(row), 4'b1011);
        rst_n = 1'b0;
        pressed = 1'b0;
        step(1);
        check("t5a_row", int'(row), 4'b1110);
        check("t5a_valid", int'(key_valid), 0);
        check("t5a_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // Reset with a token pending: token is discarded.
        press(2, 0);
        wait_valid("t5_pending");
        pressed = 1'b0;
        step(20);
        rst_n = 1'b0;
        step(1);
        check("t5b_row", int'(row), 4'b1110);
        check("t5b_valid", int'(key_valid), 0);
        check("t5b_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        t0 = tok_cnt;
        key_ready = 1'b1;
        step(20);
        check("t5_no_token", tok_cnt - t0, 0);

        // Door closing right after key 0 is emitted.
        t0 = tok_cnt;
        sb_q.push_back(KEY_0);
        press(3, 1);
        wait_valid("t6_key");
        door = 1'b1;
`ifdef SAFE_KEYPAD_DOOR_EN
        sb_q.push_back(DOOR_SEALED);
`endif
        step(30);
        pressed = 1'b0;
        step(20);
`ifdef SAFE_KEYPAD_DOOR_EN
        check("t6_tokens", tok_cnt - t0, 2);
`else
        check("t6_tokens", tok_cnt - t0, 1);
`endif

        check("sb_final", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
